// File: rtl/cdc_req_arbiter_pkg.sv
// rtl/cdc_req_arbiter_pkg.sv - shared arbiter state type and round-robin pick helper
package cdc_req_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int RR_MAX = 16;

    // Returns {found, index}: first set bit of elig searching ptr+1, ptr+2, ... modulo n.
    function automatic logic [4:0] rr_next(input logic [RR_MAX-1:0] elig,
                                           input logic [3:0]        ptr,
                                           input int                n);
        logic [4:0] pick;
        logic [3:0] idx;
        pick = '0;
        for (int off = RR_MAX; off >= 1; off--) begin
            if (off <= n) begin
                idx = 4'((int'(ptr) + off) % n);
                if (elig[idx]) pick = {1'b1, idx};
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop level synchronizer, no reset
module sync_2ff (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        meta <= d;
        q    <= meta;
    end

endmodule

// File: rtl/cdc_req_arbiter.sv
// rtl/cdc_req_arbiter.sv - round-robin arbiter for 4-phase req/ack handshakes from foreign clock domains
module cdc_req_arbiter
    import cdc_req_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255,
    localparam int ID_W   = $clog2(N_REQ),
    localparam int CNT_W  = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1)
) (
    input  logic             clk_dst,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_async,
    output logic [N_REQ-1:0] ack,
    output logic             grant_valid,
    output logic [ID_W-1:0]  grant_id,
    input  logic             done,
    output logic             timeout_err,
    output logic [ID_W-1:0]  err_id,
    input  logic             err_clr
);

    logic [N_REQ-1:0] req_s;
    logic [N_REQ-1:0] req_m;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] ack_q;
    logic [1:0]       warm;
    arb_state_t       state;
    arb_state_t       state_nx;
    logic [ID_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       pick;
    logic [ID_W-1:0]  winner;
    logic             do_grant;
    logic             do_exit;
    logic             tmo_hit;
    logic             err_set;

    for (genvar i = 0; i < N_REQ; i++) begin : g_sync
        sync_2ff u_sync (
            .clk (clk_dst),
            .d   (req_async[i]),
            .q   (req_s[i])
        );
    end

    // Synchronizer flops carry no reset, so their output is masked until they have refilled.
    assign req_m  = (warm == 2'd2) ? req_s : '0;
    assign elig   = req_m & ~ack_q;
    assign pick   = rr_next(16'(elig), 4'(rr_ptr), N_REQ);
    assign winner = ID_W'(pick[3:0]);
    assign ack    = ack_q;

    always_ff @(posedge clk_dst or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick[4])         state_nx = GRANT;
            GRANT:   if (done || tmo_hit) state_nx = IDLE;
            default:                      state_nx = IDLE;
        endcase
    end

    always_comb begin
        do_grant = (state == IDLE) && pick[4];
        tmo_hit  = (state == GRANT) && (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
        do_exit  = (state == GRANT) && (done || tmo_hit);
        err_set  = tmo_hit && !done;
    end

    always_ff @(posedge clk_dst or negedge rst_n) begin
        if (!rst_n) begin
            warm        <= '0;
            ack_q       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            rr_ptr      <= ID_W'(N_REQ - 1);
            cnt         <= '0;
            timeout_err <= 1'b0;
            err_id      <= '0;
        end else begin
            if (warm != 2'd2) warm <= warm + 2'd1;

            // The exit set overrides the release so a dropped req still sees one ack cycle.
            ack_q <= ack_q & req_m;
            if (do_exit) ack_q[grant_id] <= 1'b1;

            if (do_grant) begin
                grant_valid <= 1'b1;
                grant_id    <= winner;
                rr_ptr      <= winner;
                cnt         <= '0;
            end else if (do_exit) begin
                grant_valid <= 1'b0;
            end else if (state == GRANT) begin
                cnt <= cnt + 1'b1;
            end

            if (err_set) begin
                timeout_err <= 1'b1;
                err_id      <= grant_id;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule
